// File: rtl/mio_bus_bridge_if.sv
// Core-side data bus of the MEM-stage memory/IO bridge.
// The core drives the request; the bridge answers with read data and ready.
interface mio_bus_bridge_if;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_we;
  logic        cpu_re;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;

  modport master (
    output cpu_addr, cpu_wdata, cpu_we, cpu_re, cpu_be,
    input  cpu_rdata, cpu_ready
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we, cpu_re, cpu_be,
    output cpu_rdata, cpu_ready
  );
endinterface

// File: rtl/mio_bus_bridge.sv
// Data-side bridge: decodes core loads/stores to data RAM or to the LED,
// switch and compare/interrupt timer registers, and stalls MEM on RAM loads.
module mio_bus_bridge #(
  parameter int RAM_AW    = 10,
  parameter int LED_W     = 16,
  parameter int TMR_PRESC = 1
) (
  input  logic              clk,
  input  logic              rst,
  mio_bus_bridge_if.slave   bus,
  output logic              o_ram_en,
  output logic [3:0]        o_ram_we,
  output logic [RAM_AW-1:0] o_ram_addr,
  output logic [31:0]       o_ram_wdata,
  input  logic [31:0]       i_ram_rdata,
  input  logic [LED_W-1:0]  i_sw_in,
  output logic [LED_W-1:0]  o_led_out,
  output logic              o_timer_irq,
  output logic              o_bus_err
);

  localparam logic [31:0] PRESC_MAX = 32'(TMR_PRESC - 1);

  typedef enum logic {S_IDLE, S_RD_WAIT} state_t;

  state_t             r_state;
  logic [LED_W-1:0]   r_led;
  logic [LED_W-1:0]   r_sw1;
  logic [LED_W-1:0]   r_sw2;
  logic [31:0]        r_count;
  logic [31:0]        r_cmp;
  logic [31:0]        r_presc;
  logic               r_en;
  logic               r_irq_en;
  logic               r_pend;
  logic               r_irq;
  logic               r_bus_err;

  logic               w_wr;
  logic               w_rd;
  logic               w_idle;
  logic               w_ram_hit;
  logic               w_reg_hit;
  logic [2:0]         w_sel;
  logic               w_reg_wr;
  logic               w_tick;
  logic               w_match;
  logic [31:0]        w_reg_rdata;
  logic               w_unused;

  // A simultaneous load and store strobe is resolved as a store.
  assign w_wr      = bus.cpu_we;
  assign w_rd      = bus.cpu_re & ~bus.cpu_we;
  assign w_idle    = (r_state == S_IDLE);
  assign w_ram_hit = (bus.cpu_addr[31:RAM_AW+2] == '0);
  assign w_reg_hit = (bus.cpu_addr[31:5] == 27'h780_0000) && (bus.cpu_addr[4:2] <= 3'd4);
  assign w_sel     = bus.cpu_addr[4:2];
  assign w_reg_wr  = w_idle & w_reg_hit & w_wr;
  assign w_tick    = r_en & (r_presc == PRESC_MAX);
  assign w_match   = w_tick & (r_count == r_cmp);
  assign w_unused  = &{1'b0, bus.cpu_addr[1:0]};

  assign o_ram_addr  = bus.cpu_addr[RAM_AW+1:2];
  assign o_ram_wdata = bus.cpu_wdata;
  assign o_led_out   = r_led;
  assign o_timer_irq = r_irq;
  assign o_bus_err   = r_bus_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (w_ram_hit && w_rd) r_state <= S_RD_WAIT;
        S_RD_WAIT: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_reg_rdata = '0;
    case (w_sel)
      3'd0:    w_reg_rdata = 32'(r_led);
      3'd1:    w_reg_rdata = 32'(r_sw2);
      3'd2:    w_reg_rdata = r_count;
      3'd3:    w_reg_rdata = r_cmp;
      3'd4:    w_reg_rdata = {29'd0, r_irq_en, r_pend, r_en};
      default: w_reg_rdata = '0;
    endcase
  end

  // RAM loads are the only accesses that wait; everything else completes now.
  always_comb begin
    bus.cpu_rdata = '0;
    bus.cpu_ready = 1'b1;
    o_ram_en      = 1'b0;
    o_ram_we      = 4'd0;
    if (r_state == S_RD_WAIT) begin
      bus.cpu_rdata = i_ram_rdata;
    end else if (w_ram_hit) begin
      if (w_wr) begin
        o_ram_en = 1'b1;
        o_ram_we = bus.cpu_be;
      end else if (w_rd) begin
        o_ram_en      = 1'b1;
        bus.cpu_ready = 1'b0;
      end
    end else if (w_reg_hit && w_rd) begin
      bus.cpu_rdata = w_reg_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw1 <= '0;
      r_sw2 <= '0;
    end else begin
      r_sw1 <= i_sw_in;
      r_sw2 <= r_sw1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led     <= '0;
      r_cmp     <= 32'hFFFF_FFFF;
      r_en      <= 1'b0;
      r_irq_en  <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      if (w_reg_wr && w_sel == 3'd0) r_led <= bus.cpu_wdata[LED_W-1:0];
      if (w_reg_wr && w_sel == 3'd3) r_cmp <= bus.cpu_wdata;
      if (w_reg_wr && w_sel == 3'd4) begin
        r_en     <= bus.cpu_wdata[0];
        r_irq_en <= bus.cpu_wdata[2];
      end
      if (w_idle && (bus.cpu_we || bus.cpu_re) && !w_ram_hit && !w_reg_hit)
        r_bus_err <= 1'b1;
    end
  end

  // A CPU write to the count beats a tick; a new match beats a pending clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_count <= '0;
      r_pend  <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      if (r_en) r_presc <= w_tick ? 32'd0 : r_presc + 32'd1;
      if (w_reg_wr && w_sel == 3'd2)
        r_count <= bus.cpu_wdata;
      else if (w_tick)
        r_count <= w_match ? 32'd0 : r_count + 32'd1;
      if (w_match)
        r_pend <= 1'b1;
      else if (w_reg_wr && w_sel == 3'd4 && bus.cpu_wdata[1])
        r_pend <= 1'b0;
      r_irq <= r_pend & r_irq_en;
    end
  end

endmodule

// File: tb/tb_mio_bus_bridge.sv
// Directed bench for mio_bus_bridge: vector table for zero-wait accesses plus
// hand sequences for RAM load waits, switch sync, timer and reset corners.
module tb_mio_bus_bridge;

  logic        clk;
  logic        rst;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [15:0] sw;
  logic [15:0] led;
  logic        irq;
  logic        bus_err;

  int n_chk;
  int n_fail;

  mio_bus_bridge_if bus();

  mio_bus_bridge #(.RAM_AW(10), .LED_W(16), .TMR_PRESC(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .o_ram_en   (ram_en),
    .o_ram_we   (ram_we),
    .o_ram_addr (ram_addr),
    .o_ram_wdata(ram_wdata),
    .i_ram_rdata(ram_rdata),
    .i_sw_in    (sw),
    .o_led_out  (led),
    .o_timer_irq(irq),
    .o_bus_err  (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM with one clock of read latency.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= mem[ram_addr];
    end
  end

  typedef struct {
    logic        we;
    logic        re;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_ready;
    logic        exp_en;
    logic [3:0]  exp_we;
    logic [9:0]  exp_raddr;
  } vec_t;

  localparam int NV = 12;
  vec_t v [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.cpu_we    = 1'b0;
    bus.cpu_re    = 1'b0;
    bus.cpu_be    = 4'h0;
    bus.cpu_addr  = 32'h0;
    bus.cpu_wdata = 32'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.cpu_we = 1'b1; bus.cpu_re = 1'b0; bus.cpu_be = 4'hF;
    bus.cpu_addr = a; bus.cpu_wdata = d;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
    bus.cpu_we = 1'b0; bus.cpu_re = 1'b1; bus.cpu_addr = a;
    @(negedge clk);
    chk({name, "_rdata"}, bus.cpu_rdata, exp);
    chk({name, "_ready"}, 32'(bus.cpu_ready), 32'd1);
    @(posedge clk); #1;
    idle();
  endtask

  task automatic ram_load_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
    bus.cpu_we = 1'b0; bus.cpu_re = 1'b1; bus.cpu_addr = a;
    @(negedge clk);
    chk({name, "_wait_ready"}, 32'(bus.cpu_ready), 32'd0);
    chk({name, "_wait_ram_en"}, 32'(ram_en), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk({name, "_done_ready"}, 32'(bus.cpu_ready), 32'd1);
    chk({name, "_done_rdata"}, bus.cpu_rdata, exp);
    chk({name, "_done_ram_en"}, 32'(ram_en), 32'd0);
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    ram_rdata = 32'h0;
    sw = 16'h0;
    idle();

    //      we    re    be    addr          wdata         rdata         rdy   en    we    raddr
    v[0]  = '{1'b0, 1'b1, 4'h0, 32'hF000000C, 32'h0,        32'hFFFFFFFF, 1'b1, 1'b0, 4'h0, 10'd3};
    v[1]  = '{1'b0, 1'b1, 4'h0, 32'hF0000010, 32'h0,        32'h00000000, 1'b1, 1'b0, 4'h0, 10'd4};
    v[2]  = '{1'b0, 1'b1, 4'h0, 32'hF0000008, 32'h0,        32'h00000000, 1'b1, 1'b0, 4'h0, 10'd2};
    v[3]  = '{1'b0, 1'b1, 4'h0, 32'hF0000004, 32'h0,        32'h00000000, 1'b1, 1'b0, 4'h0, 10'd1};
    v[4]  = '{1'b0, 1'b0, 4'h0, 32'h00000000, 32'h0,        32'h00000000, 1'b1, 1'b0, 4'h0, 10'd0};
    v[5]  = '{1'b1, 1'b0, 4'hF, 32'h00000010, 32'hDEADBEEF, 32'h00000000, 1'b1, 1'b1, 4'hF, 10'd4};
    v[6]  = '{1'b1, 1'b0, 4'h3, 32'h00000020, 32'hCAFEF00D, 32'h00000000, 1'b1, 1'b1, 4'h3, 10'd8};
    v[7]  = '{1'b1, 1'b0, 4'h0, 32'hF0000000, 32'h0001FFFF, 32'h00000000, 1'b1, 1'b0, 4'h0, 10'd0};
    v[8]  = '{1'b0, 1'b1, 4'h0, 32'hF0000000, 32'h0,        32'h0000FFFF, 1'b1, 1'b0, 4'h0, 10'd0};
    v[9]  = '{1'b1, 1'b1, 4'hF, 32'hF000000C, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 4'h0, 10'd3};
    v[10] = '{1'b0, 1'b1, 4'h0, 32'hF000000C, 32'h0,        32'h12345678, 1'b1, 1'b0, 4'h0, 10'd3};
    v[11] = '{1'b0, 1'b1, 4'h0, 32'hF0000003, 32'h0,        32'h0000FFFF, 1'b1, 1'b0, 4'h0, 10'd0};

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",   32'(bus.cpu_ready), 32'd1);
    chk("rst_rdata",   bus.cpu_rdata, 32'd0);
    chk("rst_ram_en",  32'(ram_en), 32'd0);
    chk("rst_led",     32'(led), 32'd0);
    chk("rst_irq",     32'(irq), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      bus.cpu_we    = v[i].we;
      bus.cpu_re    = v[i].re;
      bus.cpu_be    = v[i].be;
      bus.cpu_addr  = v[i].addr;
      bus.cpu_wdata = v[i].wdata;
      @(negedge clk);
      chk($sformatf("vec%0d_rdata", i),  bus.cpu_rdata, v[i].exp_rdata);
      chk($sformatf("vec%0d_ready", i),  32'(bus.cpu_ready), 32'(v[i].exp_ready));
      chk($sformatf("vec%0d_ram_en", i), 32'(ram_en), 32'(v[i].exp_en));
      chk($sformatf("vec%0d_ram_we", i), 32'(ram_we), 32'(v[i].exp_we));
      chk($sformatf("vec%0d_ram_addr", i), 32'(ram_addr), 32'(v[i].exp_raddr));
      @(posedge clk); #1;
      idle();
    end
    chk("table_bus_err", 32'(bus_err), 32'd0);

    // RAM loads, back to back
    ram_load_chk(32'h00000010, 32'hDEADBEEF, "load10");
    ram_load_chk(32'h00000020, 32'h0000F00D, "load20");
    ram_load_chk(32'h00000010, 32'hDEADBEEF, "load10b");

    // LED register
    wr(32'hF0000000, 32'h0000A5A5);
    chk("led_out", 32'(led), 32'h0000A5A5);
    rd_chk(32'hF0000000, 32'h0000A5A5, "led_rd");

    // Switch synchroniser
    sw = 16'h1234;
    rd_chk(32'hF0000004, 32'h0, "sw_edge0");
    rd_chk(32'hF0000004, 32'h0, "sw_edge1");
    rd_chk(32'hF0000004, 32'h1234, "sw_edge2");

    // Timer count/match/irq
    wr(32'hF000000C, 32'd3);
    wr(32'hF0000010, 32'h5);
    for (int i = 0; i < 4; i++) rd_chk(32'hF0000008, 32'(i), $sformatf("tmr_cnt%0d", i));
    chk("irq_before", 32'(irq), 32'd0);
    rd_chk(32'hF0000010, 32'h7, "tmr_pend_set");
    chk("irq_set", 32'(irq), 32'd1);
    wr(32'hF0000010, 32'h2);
    chk("irq_hold", 32'(irq), 32'd1);
    @(posedge clk); #1;
    chk("irq_drop", 32'(irq), 32'd0);
    rd_chk(32'hF0000010, 32'h0, "tmr_cleared");

    // Clear coinciding with a match: set wins
    wr(32'hF0000008, 32'd3);
    wr(32'hF0000010, 32'h5);
    wr(32'hF0000010, 32'h7);
    rd_chk(32'hF0000008, 32'd0, "tmr_wrap_cnt");
    rd_chk(32'hF0000010, 32'h7, "tmr_set_wins");
    // CPU write to count in a tick cycle: write wins
    wr(32'hF0000008, 32'h100);
    rd_chk(32'hF0000008, 32'h100, "tmr_write_wins");
    wr(32'hF0000010, 32'h2);

    // Unmapped accesses
    bus.cpu_re = 1'b1; bus.cpu_addr = 32'h80000000;
    @(negedge clk);
    chk("unm_rdata",  bus.cpu_rdata, 32'd0);
    chk("unm_ready",  32'(bus.cpu_ready), 32'd1);
    chk("unm_ram_en", 32'(ram_en), 32'd0);
    @(posedge clk); #1;
    idle();
    chk("unm_bus_err", 32'(bus_err), 32'd1);
    wr(32'h80000000, 32'h00000055);
    rd_chk(32'hF0000000, 32'h0000A5A5, "unm_led_kept");
    rd_chk(32'hF000000C, 32'd3, "unm_cmp_kept");
    chk("unm_bus_err_sticky", 32'(bus_err), 32'd1);

    // Reset while waiting on a RAM load
    bus.cpu_re = 1'b1; bus.cpu_addr = 32'h00000010;
    @(posedge clk); #1;
    rst = 1'b1;
    idle();
    #1;
    chk("rdw_rst_ready",   32'(bus.cpu_ready), 32'd1);
    chk("rdw_rst_rdata",   bus.cpu_rdata, 32'd0);
    chk("rdw_rst_led",     32'(led), 32'd0);
    chk("rdw_rst_bus_err", 32'(bus_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    ram_load_chk(32'h00000010, 32'hDEADBEEF, "post_rst_load");
    rd_chk(32'hF000000C, 32'hFFFFFFFF, "post_rst_cmp");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mio_bus_bridge.md
Name: mio_bus_bridge

Overview:
- Data-side memory/IO bridge sitting directly downstream of the pipelined RISC-V core's MEM stage.
- Consumes the core's address, write data and write/read strobes, and decodes them to data RAM or on-chip peripheral registers.
- Peripherals: LED register, synchronised switch port, and a compare/interrupt timer.
- Returns read data plus a ready handshake, which the core uses as MIO_ready to stall MEM.

Parameters:
- RAM_AW, 10, RAM word-address width (RAM window = 4*2^RAM_AW bytes from 0x0000_0000).
- LED_W, 16, width of the LED output register and switch input.
- TMR_PRESC, 1, timer ticks once every TMR_PRESC clocks (must be >=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- cpu_addr  in  32  byte address from the core's EX/MEM ALU result.
- cpu_wdata  in  32  store data.
- cpu_we  in  1  store strobe (MemWrite).
- cpu_re  in  1  load strobe.
- cpu_be  in  4  byte enables (RAM only).
- cpu_rdata  out  32  load data.
- cpu_ready  out  1  request completes this cycle (MIO_ready).
- ram_en  out  1  RAM access enable.
- ram_we  out  4  RAM byte write enables.
- ram_addr  out  RAM_AW  RAM word address (cpu_addr[RAM_AW+1:2]).
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid one clock after ram_en.
- sw_in  in  LED_W  asynchronous switch inputs.
- led_out  out  LED_W  LED register.
- timer_irq  out  1  timer interrupt (the core's INT).
- bus_err  out  1  sticky unmapped-access flag.

Behaviour:
- Reset values: all outputs 0 except cpu_ready=1. State=IDLE, led=0, tmr_count=0, tmr_cmp=0xFFFF_FFFF, tmr_ctrl=0, pending=0, presc=0, sw sync flops=0.
- Address map (word-decoded; cpu_addr[1:0] ignored):
  - RAM window: 0x0000_0000 up to the RAM window size.
  - 0xF000_0000: LED register, R/W, low LED_W bits.
  - 0xF000_0004: switches, read-only, zero-extended.
  - 0xF000_0008: tmr_count, R/W.
  - 0xF000_000C: tmr_cmp, R/W.
  - 0xF000_0010: control/status. bit0=enable, bit2=irq_en (both R/W). bit1=pending (read; write 1 to clear).
  - All other addresses: unmapped.
- cpu_we and cpu_re both high: treated as a write.
- FSM states IDLE and RD_WAIT.
  - IDLE, RAM read: ram_en=1, cpu_ready=0, next state RD_WAIT.
  - RD_WAIT: cpu_ready=1, cpu_rdata=ram_rdata, ram_en=0, next state IDLE. The core holds the request stable while cpu_ready=0.
  - RAM write: zero-wait. ram_en=1 and ram_we=cpu_be in the same cycle, cpu_ready=1, state stays IDLE.
  - Register read/write: zero-wait, cpu_ready=1. Read data is combinational from the registers. Writes commit at the clock edge; cpu_be is ignored, full word.
  - No request: cpu_ready=1, cpu_rdata=0.
- Unmapped access: reads return 0, writes are dropped, cpu_ready=1, bus_err set. bus_err clears only on reset.
- Switches: two-flop synchroniser. A read returns the second-stage value.
- Timer:
  - Prescaler counts 0..TMR_PRESC-1 while enable=1. On wrap it issues a tick.
  - Tick with tmr_count==tmr_cmp: tmr_count<=0 and pending<=1. Otherwise a tick increments tmr_count, wrapping at 2^32.
  - Clearing enable freezes the count and the prescaler.
  - CPU write to tmr_count in a tick cycle: the write wins.
  - A pending-clear write in the same cycle as a new match: set wins.
  - timer_irq = pending & irq_en, registered (one cycle after pending rises).
- Reset asserted in RD_WAIT: FSM forced to IDLE, no data returned, no register modified.

Test Plan:
- RAM store to 0x10 with cpu_be=4'b1111, data 0xDEADBEEF; then load 0x10 -> store has ram_we=4'hF, cpu_ready=1 in the same cycle. Load has cpu_ready=0 for 1 cycle, then cpu_rdata=0xDEADBEEF with cpu_ready=1. Back-to-back loads each take exactly 2 cycles.
- Write 0x0000A5A5 to 0xF000_0000 -> led_out=0xA5A5 the next cycle. A read returns 0x0000A5A5 with zero wait.
- Drive sw_in=0x1234 -> a read of 0xF000_0004 returns 0x1234 from the 2nd clock after the change, and the old value before that.
- TMR_PRESC=1, tmr_cmp=3, ctrl=0x5 -> count 0,1,2,3,0. pending=1 on the wrap edge, timer_irq=1 one cycle later. Write 0x2 to 0xF000_0010 -> irq drops. A clear coinciding with a match leaves pending=1.
- Load 0x8000_0000 -> cpu_rdata=0, cpu_ready=1, bus_err=1 and stays 1. A store there changes no register.
- Assert rst during RD_WAIT -> cpu_ready=1, led_out=0, state IDLE. A subsequent load completes normally in 2 cycles.
